// File: rtl/fsm_rr_sched.sv
// fsm_rr_sched: four-way round-robin grant scheduler with bounded tenure.
//
// Requests are level-sensitive. Grants are one-hot and come straight from registers.
// A grant is held until its requester drops the request. Every release is followed
// by GAP_CYCLES cycles with all grants low, so the shared resource can settle.
//
// Optional feature, enabled by defining the macro FSM_RR_SCHED_TIMEOUT_EN:
//   While another agent is waiting, a grant is force-released after MAX_HOLD cycles,
//   and `preempt` pulses for one cycle on each forced release.
//   Without the macro:
//     - the hold counter is not built;
//     - `preempt` is tied low;
//     - MAX_HOLD is ignored.
//
// Handshake: there is no valid/ready pair. Each req_x is a level. It is held high
// for as long as agent x wants the resource. gnt_x is high for exactly the cycles in
// which agent x owns the resource. An owner must keep its request high to keep
// ownership. Dropping the request is the release.

module fsm_rr_sched #(
   parameter int MAX_HOLD   = 8,   // 1..255, forced-release limit (timeout build only)
   parameter int GAP_CYCLES = 1    // 1..15, dead cycles after every release
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_0,
   input  logic       req_1,
   input  logic       req_2,
   input  logic       req_3,
   output logic       gnt_0,
   output logic       gnt_1,
   output logic       gnt_2,
   output logic       gnt_3,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       preempt,
   output logic [1:0] state_o      // debug view of the FSM state register
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   // Catch illegal parameter values at elaboration time.
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("fsm_rr_sched: MAX_HOLD must be in 1..255");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("fsm_rr_sched: GAP_CYCLES must be in 1..15");
   end

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;

   logic [3:0] req_vec;
   logic       win_found;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       release_grant;

`ifdef FSM_RR_SCHED_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [7:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;
   logic       others_waiting;
   logic       hold_expired;
`endif

   assign req_vec = {req_3, req_2, req_1, req_0};

   // Rotating-priority search: scan ptr, ptr+1, ... and keep the first requester.
   // The loop runs from the farthest offset down to the nearest one, so the
   // nearest requester is written last and wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr_q + 2'(i);
         if (req_vec[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef FSM_RR_SCHED_TIMEOUT_EN
   // Detect contention and expiry of the hold limit.
   // The >= comparison covers a contender that arrives after the counter has
   // saturated, so a late arrival still forces the release on the next cycle.
   always_comb begin
      others_waiting = |(req_vec & ~gnt_q);
      hold_expired   = (hold_q >= (HOLD_MAX - 8'd1));
   end
`endif

   // Next-state and next-output logic for the IDLE -> GNT -> GAP -> IDLE cycle.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      gnt_id_d      = gnt_id_q;
      ptr_d         = ptr_q;
      gap_cnt_d     = gap_cnt_q;
      release_grant = 1'b0;
`ifdef FSM_RR_SCHED_TIMEOUT_EN
      hold_d        = hold_q;
      preempt_d     = 1'b0;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d  = S_GNT;
               gnt_d    = 4'b0001 << win_idx;
               gnt_id_d = win_idx;
`ifdef FSM_RR_SCHED_TIMEOUT_EN
               hold_d   = 8'd0;
`endif
            end
         end

         S_GNT: begin
`ifdef FSM_RR_SCHED_TIMEOUT_EN
            if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 8'd1;
            end
`endif
            if (!req_vec[gnt_id_q]) begin
               // The owner let go voluntarily. This takes precedence over a timeout
               // that expires on the same edge, so no preempt pulse is raised.
               release_grant = 1'b1;
            end
`ifdef FSM_RR_SCHED_TIMEOUT_EN
            else if (hold_expired && others_waiting) begin
               release_grant = 1'b1;
               preempt_d     = 1'b1;
            end
`endif
            if (release_grant) begin
               state_d   = S_GAP;
               gnt_d     = 4'b0000;
               ptr_d     = gnt_id_q + 2'd1;
               gap_cnt_d = 4'd0;
            end
         end

         S_GAP: begin
            // Requests are ignored here. The resource settles for GAP_CYCLES cycles.
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_IDLE;
               gap_cnt_d = 4'd0;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end

         default: begin
            state_d   = S_IDLE;
            gnt_d     = 4'b0000;
            gap_cnt_d = 4'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         gnt_q     <= 4'b0000;
         gnt_id_q  <= 2'd0;
         ptr_q     <= 2'd0;
         gap_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

`ifdef FSM_RR_SCHED_TIMEOUT_EN
   // Hold counter and preempt pulse registers; these exist only in the timeout build.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

   assign gnt_0   = gnt_q[0];
   assign gnt_1   = gnt_q[1];
   assign gnt_2   = gnt_q[2];
   assign gnt_3   = gnt_q[3];
   assign gnt_id  = gnt_id_q;
   assign busy    = (state_q != S_IDLE);
   assign state_o = state_q;

endmodule

// File: tb/tb_fsm_rr_sched.sv
// Testbench for fsm_rr_sched (MAX_HOLD=4, GAP_CYCLES=1).
// Directed vectors are checked one cycle at a time.
// The timeout-dependent sequence follows the FSM_RR_SCHED_TIMEOUT_EN macro.

module tb_fsm_rr_sched;

   logic       clock;
   logic       reset;
   logic       req_0, req_1, req_2, req_3;
   logic       gnt_0, gnt_1, gnt_2, gnt_3;
   logic [1:0] gnt_id;
   logic       busy;
   logic       preempt;
   logic [1:0] dbg_state;

   int n_cmp;
   int n_err;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] exp_gnt;
      logic [1:0] exp_id;
      logic       exp_busy;
      logic       exp_pre;
   } vec_t;

   vec_t vecs[12];

   fsm_rr_sched #(
      .MAX_HOLD   (4),
      .GAP_CYCLES (1)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .req_0   (req_0),
      .req_1   (req_1),
      .req_2   (req_2),
      .req_3   (req_3),
      .gnt_0   (gnt_0),
      .gnt_1   (gnt_1),
      .gnt_2   (gnt_2),
      .gnt_3   (gnt_3),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .preempt (preempt),
      .state_o (dbg_state)
   );

   // Clock generation.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic set_req(input logic [3:0] r);
      req_0 = r[0];
      req_1 = r[1];
      req_2 = r[2];
      req_3 = r[3];
   endtask

   // Advance one rising edge, then settle away from the edge before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                                input logic eb, input logic ep);
      logic [3:0] g;
      g = {gnt_3, gnt_2, gnt_1, gnt_0};
      n_cmp++;
      if (g !== eg) begin
         n_err++;
         $display("FAIL %s gnt: got %b want %b", tag, g, eg);
      end
      check_bit({tag, " busy"}, busy, eb);
      check_bit({tag, " preempt"}, preempt, ep);
      // gnt_id is defined only while busy.
      if (eb) begin
         n_cmp++;
         if (gnt_id !== eid) begin
            n_err++;
            $display("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, eid);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_req(4'h0);
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      set_req(4'hF);

      // ---------------------------------------------------------------
      // Table: reset with all requests high, first grant, then a single
      // requester on agent 2 for five cycles.
      // ---------------------------------------------------------------
      vecs[0]  = '{1'b1, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'hF, 4'b0001, 2'd0, 1'b1, 1'b0};  // gnt_0 first after reset
      vecs[3]  = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0};  // release -> GAP
      vecs[4]  = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0};  // IDLE, ptr=1
      vecs[5]  = '{1'b0, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 4'h0, 4'b0000, 2'd2, 1'b1, 1'b0};  // one busy GAP cycle
      vecs[11] = '{1'b0, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         reset = vecs[i].rst;
         set_req(vecs[i].req);
         step();
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_id,
                       vecs[i].exp_busy, vecs[i].exp_pre);
      end

      // ---------------------------------------------------------------
      // Rotation: all agents request. Each owner drops its request on the
      // fourth edge of its tenure, for that edge only. Period is 5 edges:
      // 3 grant, 1 gap, 1 idle.
      // ---------------------------------------------------------------
      do_reset();
      for (int e = 1; e <= 23; e++) begin
         int         p;
         int         a;
         logic [3:0] r;
         logic [3:0] eg;
         p = (e - 1) % 5;
         a = ((e - 1) / 5) % 4;
         r = 4'hF;
         if (p == 3) r[a] = 1'b0;
         eg = (p <= 2) ? (4'b0001 << a) : 4'b0000;
         set_req(r);
         step();
         check_outputs($sformatf("rot e%0d", e), eg, 2'(a), (p <= 3), 1'b0);
      end

`ifdef FSM_RR_SCHED_TIMEOUT_EN
      // ---------------------------------------------------------------
      // Timeout: req_0 and req_1 are held high. Each tenure lasts 4 edges,
      // followed by a preempt/GAP edge and an IDLE edge.
      // ---------------------------------------------------------------
      do_reset();
      for (int e = 1; e <= 14; e++) begin
         int         p;
         int         a;
         logic [3:0] eg;
         p = (e - 1) % 6;
         a = ((e - 1) / 6) % 2;
         eg = (p <= 3) ? (4'b0001 << a) : 4'b0000;
         set_req(4'b0011);
         step();
         check_outputs($sformatf("tmo e%0d", e), eg, 2'(a), (p <= 4), (p == 4));
      end
`else
      // ---------------------------------------------------------------
      // No timeout: a held request on agent 0 starves agent 1.
      // ---------------------------------------------------------------
      do_reset();
      for (int e = 1; e <= 14; e++) begin
         set_req(4'b0011);
         step();
         check_outputs($sformatf("starve e%0d", e), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`endif

      // ---------------------------------------------------------------
      // Lone holder: req_3 alone for 20 edges is never preempted.
      // ---------------------------------------------------------------
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         set_req(4'b1000);
         step();
         check_outputs($sformatf("lone e%0d", e), 4'b1000, 2'd3, 1'b1, 1'b0);
      end

      // ---------------------------------------------------------------
      // Mid-grant reset: gnt_1 is active, then reset is pulsed for one edge
      // while req_1 stays high.
      // ---------------------------------------------------------------
      do_reset();
      set_req(4'b0010);
      step();
      check_outputs("mid e1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      check_outputs("mid e2", 4'b0010, 2'd1, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      check_outputs("mid rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_bit("mid rst gnt_id", gnt_id[0], 1'b0);
      reset = 1'b0;
      step();
      check_outputs("mid regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
